// File: rtl/hough_theta_sequencer.sv
// Angle sweep sequencer feeding a combinational CORDIC and streaming signed (sin, cos, idx) triples.
// Optional HOUGH_THETA_GAIN_COMP_EN adds a rounded 1/K scaling stage between capture and output.
module hough_theta_sequencer #(
  parameter int N_THETA      = 180,
  parameter int IDX_W        = 8,
  parameter int THETA_STEP   = 286,
  parameter int PI_Q214      = 51472,
  parameter int HALF_PI_Q214 = 25736,
  parameter int CORDIC_WAIT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [15:0]      cordic_z,
  input  logic [15:0]      cordic_sin,
  input  logic [15:0]      cordic_cos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [16:0]      out_sin,
  output logic [16:0]      out_cos,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
`ifdef HOUGH_THETA_GAIN_COMP_EN
  localparam logic [2:0] S_CMP   = 3'd3;
`endif
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int              WC_W      = (CORDIC_WAIT > 1) ? $clog2(CORDIC_WAIT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(CORDIC_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_THETA - 1);
  localparam logic [15:0]     STEP16    = 16'(THETA_STEP);
  localparam logic [15:0]     PI16      = 16'(PI_Q214);
  localparam logic [15:0]     HALF_PI16 = 16'(HALF_PI_Q214);

  logic [2:0]       state_reg;
  logic [15:0]      theta_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WC_W-1:0]  wait_cnt_reg;
  logic             neg_reg;

  logic [15:0] sin_mag;
  logic [15:0] cos_mag;
  logic [16:0] sin_ext;
  logic [16:0] cos_ext;

`ifdef HOUGH_THETA_GAIN_COMP_EN
  logic [15:0] sin_raw_reg;
  logic [15:0] cos_raw_reg;

  // 0x4DBA is 1/K in Q1.15; adding 2^14 rounds to nearest before the >>15.
  assign sin_mag = 16'((32'(sin_raw_reg) * 32'd19898 + 32'd16384) >> 15);
  assign cos_mag = 16'((32'(cos_raw_reg) * 32'd19898 + 32'd16384) >> 15);
`else
  assign sin_mag = cordic_sin;
  assign cos_mag = cordic_cos;
`endif

  // Sine is never negative on [0, pi]; cosine flips sign for folded angles.
  assign sin_ext = {1'b0, sin_mag};
  assign cos_ext = neg_reg ? (17'd0 - {1'b0, cos_mag}) : {1'b0, cos_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      theta_reg    <= '0;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      neg_reg      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cordic_z     <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_sin      <= '0;
      out_cos      <= '0;
`ifdef HOUGH_THETA_GAIN_COMP_EN
      sin_raw_reg  <= '0;
      cos_raw_reg  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            theta_reg <= '0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (theta_reg <= HALF_PI16) begin
            cordic_z <= theta_reg;
            neg_reg  <= 1'b0;
          end else begin
            cordic_z <= PI16 - theta_reg;
            neg_reg  <= 1'b1;
          end
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
`ifdef HOUGH_THETA_GAIN_COMP_EN
            sin_raw_reg <= cordic_sin;
            cos_raw_reg <= cordic_cos;
            state_reg   <= S_CMP;
`else
            out_sin   <= sin_ext;
            out_cos   <= cos_ext;
            out_idx   <= idx_reg;
            out_valid <= 1'b1;
            state_reg <= S_OUT;
`endif
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
`ifdef HOUGH_THETA_GAIN_COMP_EN
        S_CMP: begin
          out_sin   <= sin_ext;
          out_cos   <= cos_ext;
          out_idx   <= idx_reg;
          out_valid <= 1'b1;
          state_reg <= S_OUT;
        end
`endif
        S_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              theta_reg <= theta_reg + STEP16;
              state_reg <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The last angle must stay below pi or the fold subtraction underflows.
  param_range_check: assert property (@(posedge clk) disable iff (!rst_n)
    ((N_THETA - 1) * THETA_STEP < PI_Q214) && (N_THETA >= 1) && (CORDIC_WAIT >= 1)
    && ((1 << IDX_W) >= N_THETA));
`endif

endmodule
